memory_r2_down_2_access: RTL

- Serial access controller for tank r2_down_2: 16 long words / 32 short words recirculating at one digit per r2_clk.
- Tracks tank position with a digit counter and a minor-cycle counter.
- Accepts one read or write request at a time and waits until the addressed word passes the head.
- Drives the tank strobes (t2_in, t2_out, t2_clr) and the serial input r2_mib; deserialises r2_down_mob_t2 into a parallel read word.

---
 rtl/memory_r2_down_2_access.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/memory_r2_down_2_access.sv
// Serial access controller for tank r2_down_2: waits for the addressed word at the head, then streams it in or out.
// Latency req->ack = wait (0..575) + L + 1; one request at a time, req ignored unless IDLE (busy gives the backpressure).
module memory_r2_down_2_access #(
    parameter int DIGITS       = 18,
    parameter int MINOR_CYCLES = 32,
    parameter int DATA_W       = 35
) (
    input  logic              r2_clk,
    input  logic              r2_rst_n,
    input  logic              req,
    input  logic              we,
    input  logic              long,
    input  logic [4:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [4:0]        mc_pos,
    output logic              r2_mib,
    output logic              r2_down_t2_in,
    output logic              r2_down_t2_out,
    output logic              r2_down_t2_clr,
    input  logic              r2_down_mob_t2
);
    localparam int SHORT_W = 17;
    localparam int DW      = $clog2(DIGITS);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
    localparam logic [4:0]    MC_LAST  = 5'(MINOR_CYCLES - 1);
    localparam logic [5:0]    K_LONG   = 6'(DATA_W - 1);
    localparam logic [5:0]    K_SHORT  = 6'(SHORT_W - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t            state, state_n;
    logic [DW-1:0]     digit;
    logic [4:0]        mc_next;
    logic              wrap;
    logic              we_q, long_q;
    logic [4:0]        addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cap, cap_full;
    logic [5:0]        k, k_n, k_last;
    logic              load, go, go_we, go_bit;
    logic              busy_n, ack_n, err_n;

    assign wrap    = (digit == DIG_LAST);
    assign mc_next = (mc_pos == MC_LAST) ? 5'd0 : mc_pos + 5'd1;
    assign k_last  = long_q ? K_LONG : K_SHORT;

    // Outputs are registered, so every decision looks one cycle ahead:
    // "hit" means the addressed word's digit 0 is at the head next cycle.
    always_comb begin
        state_n = state;
        k_n     = k;
        load    = 1'b0;
        go      = 1'b0;
        go_we   = 1'b0;
        go_bit  = 1'b0;
        busy_n  = 1'b0;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (long && addr[0]) begin
                        err_n = 1'b1;
                    end else begin
                        load   = 1'b1;
                        busy_n = 1'b1;
                        if (wrap && mc_next == addr) begin
                            state_n = XFER;
                            k_n     = 6'd0;
                            go      = 1'b1;
                            go_we   = we;
                            go_bit  = wdata[0];
                        end else begin
                            state_n = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                busy_n = 1'b1;
                if (wrap && mc_next == addr_q) begin
                    state_n = XFER;
                    k_n     = 6'd0;
                    go      = 1'b1;
                    go_we   = we_q;
                    go_bit  = wdata_q[0];
                end
            end
            XFER: begin
                if (k == k_last) begin
                    state_n = DONE;
                    ack_n   = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    k_n    = k + 6'd1;
                    go     = 1'b1;
                    go_we  = we_q;
                    go_bit = wdata_q[k_n];
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cap_full    = cap;
        cap_full[k] = r2_down_mob_t2;
        if (!long_q) cap_full[DATA_W-1:SHORT_W] = '0;
    end

    always_ff @(posedge r2_clk or negedge r2_rst_n) begin
        if (!r2_rst_n) begin
            state          <= IDLE;
            digit          <= '0;
            mc_pos         <= '0;
            k              <= '0;
            we_q           <= 1'b0;
            long_q         <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cap            <= '0;
            rdata          <= '0;
            busy           <= 1'b0;
            ack            <= 1'b0;
            err            <= 1'b0;
            r2_mib         <= 1'b0;
            r2_down_t2_in  <= 1'b0;
            r2_down_t2_out <= 1'b0;
            r2_down_t2_clr <= 1'b0;
        end else begin
            digit <= wrap ? '0 : digit + DW'(1);
            if (wrap) mc_pos <= mc_next;
            state          <= state_n;
            k              <= k_n;
            busy           <= busy_n;
            ack            <= ack_n;
            err            <= err_n;
            r2_down_t2_in  <= go & go_we;
            r2_down_t2_clr <= go & go_we;
            r2_down_t2_out <= go & ~go_we;
            r2_mib         <= go & go_we & go_bit;
            if (load) begin
                we_q    <= we;
                long_q  <= long;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            // rdata only changes when a read finishes, so it holds between reads.
            if (state == XFER && !we_q) begin
                cap[k] <= r2_down_mob_t2;
                if (k == k_last) rdata <= cap_full;
            end
        end
    end
endmodule
